// File: rtl/dispatch_if.sv
// Shared instruction/CDB types and the dispatch-stage bus: rename group, CDB, and
// per-station credit/write ports.
package uarch_pkg;
  localparam int PIPE_WIDTH = 2;
  localparam int TAG_W      = 6;
  localparam int DATA_W     = 32;

  typedef enum logic [3:0] {
    OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
    OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR
  } opcode_t;

  typedef struct packed {
    logic              is_renamed;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } src_t;

  typedef struct packed {
    logic             is_valid;
    opcode_t          opcode;
    logic [TAG_W-1:0] dst_tag;
    src_t             src_0_a;
    src_t             src_0_b;
    src_t             src_1_a;
    src_t             src_1_b;
  } instruction_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_port_t;
endpackage

interface dispatch_if;
  import uarch_pkg::*;

  logic                             flush;
  logic                             dispatch_rdy;
  instruction_t [PIPE_WIDTH-1:0]    renamed_insts;
  cdb_port_t    [PIPE_WIDTH-1:0]    cdb_ports;
  logic [1:0]                       alu_rs_credit, mem_rs_credit, br_rs_credit;
  logic [PIPE_WIDTH-1:0]            alu_rs_we, mem_rs_we, br_rs_we;
  instruction_t [PIPE_WIDTH-1:0]    alu_rs_insts, mem_rs_insts, br_rs_insts;

  modport master (
    output flush, renamed_insts, cdb_ports, alu_rs_credit, mem_rs_credit, br_rs_credit,
    input  dispatch_rdy, alu_rs_we, mem_rs_we, br_rs_we, alu_rs_insts, mem_rs_insts, br_rs_insts
  );

  modport slave (
    input  flush, renamed_insts, cdb_ports, alu_rs_credit, mem_rs_credit, br_rs_credit,
    output dispatch_rdy, alu_rs_we, mem_rs_we, br_rs_we, alu_rs_insts, mem_rs_insts, br_rs_insts
  );
endinterface

// File: rtl/dispatch.sv
// In-order dispatch buffer routing renamed instructions to ALU/MEM/BR stations with CDB snoop.
// Optional same-cycle bypass into the stations when the buffer is empty: DISPATCH_BYPASS_EN.
module dispatch
  import uarch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  dispatch_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LW    = $clog2(PIPE_WIDTH);
  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_MEM = 2'd1;
  localparam logic [1:0] CLS_BR  = 2'd2;

  instruction_t buf_q [DEPTH];
  instruction_t buf_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic rdy;

  instruction_t comp [PIPE_WIDTH];
  instruction_t cand [PIPE_WIDTH];
  instruction_t [PIPE_WIDTH-1:0] st_insts [3];
  logic [PIPE_WIDTH-1:0] st_we [3];
  logic [1:0] cred [3];
  int out_n [3];
  int comp_n, cand_n, deq_n, byp_n, buf_deq_n, enq_n;
  logic stop, bypass;
  logic [1:0] cls;

  function automatic src_t snoop_src(input src_t s, input cdb_port_t [PIPE_WIDTH-1:0] cdb);
    src_t r;
    logic hit;
    r   = s;
    hit = 1'b0;
    for (int p = 0; p < PIPE_WIDTH; p++) begin
      if (!hit && s.is_renamed && cdb[p].valid && cdb[p].tag == s.tag) begin
        hit          = 1'b1;
        r.is_renamed = 1'b0;
        r.tag        = '0;
        r.data       = cdb[p].data;
      end
    end
    return r;
  endfunction

  function automatic instruction_t snoop_inst(input instruction_t i, input cdb_port_t [PIPE_WIDTH-1:0] cdb);
    instruction_t r;
    r         = i;
    r.src_0_a = snoop_src(i.src_0_a, cdb);
    r.src_0_b = snoop_src(i.src_0_b, cdb);
    r.src_1_a = snoop_src(i.src_1_a, cdb);
    r.src_1_b = snoop_src(i.src_1_b, cdb);
    return r;
  endfunction

  function automatic logic [1:0] classify(input opcode_t op);
    case (op)
      OPC_LOAD, OPC_STORE:           return CLS_MEM;
      OPC_BRANCH, OPC_JAL, OPC_JALR: return CLS_BR;
      default:                       return CLS_ALU;
    endcase
  endfunction

  always_comb begin
    rdy = !rst && (count_q <= CNT_W'(DEPTH - PIPE_WIDTH));
    for (int i = 0; i < DEPTH; i++) buf_d[i] = snoop_inst(buf_q[i], bus.cdb_ports);

    // Compact valid lanes so invalid lanes never consume an entry
    comp_n = 0;
    for (int l = 0; l < PIPE_WIDTH; l++) comp[l] = '0;
    for (int l = 0; l < PIPE_WIDTH; l++) begin
      if (bus.renamed_insts[l].is_valid) begin
        comp[LW'(comp_n)] = snoop_inst(bus.renamed_insts[l], bus.cdb_ports);
        comp_n = comp_n + 1;
      end
    end

    bypass = 1'b0;
`ifdef DISPATCH_BYPASS_EN
    bypass = rdy && (count_q == '0);
`endif
    for (int k = 0; k < PIPE_WIDTH; k++)
      cand[k] = bypass ? comp[k] : snoop_inst(buf_q[head_q + PTR_W'(k)], bus.cdb_ports);
    cand_n = bypass ? comp_n : int'(count_q);

    cred[CLS_ALU] = bus.alu_rs_credit;
    cred[CLS_MEM] = bus.mem_rs_credit;
    cred[CLS_BR]  = bus.br_rs_credit;
    for (int c = 0; c < 3; c++) begin
      out_n[c]    = 0;
      st_we[c]    = '0;
      st_insts[c] = '0;
    end
    cls   = CLS_ALU;
    deq_n = 0;
    stop  = rst || bus.flush;
    // First stall ends the scan so younger entries never pass an older one
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      cls = classify(cand[k].opcode);
      if (!stop && k < cand_n && cred[cls] != 2'd0) begin
        cred[cls] = cred[cls] - 2'd1;
        st_we[cls][LW'(out_n[cls])]    = 1'b1;
        st_insts[cls][LW'(out_n[cls])] = cand[k];
        out_n[cls] = out_n[cls] + 1;
        deq_n      = deq_n + 1;
      end else begin
        stop = 1'b1;
      end
    end

    byp_n     = bypass ? deq_n : 0;
    buf_deq_n = bypass ? 0 : deq_n;
    enq_n     = 0;
    if (rdy && !bus.flush) begin
      for (int j = 0; j < PIPE_WIDTH; j++) begin
        if (j >= byp_n && j < comp_n) begin
          buf_d[tail_q + PTR_W'(enq_n)] = comp[j];
          enq_n = enq_n + 1;
        end
      end
    end

    head_d  = head_q + PTR_W'(buf_deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + CNT_W'(enq_n) - CNT_W'(buf_deq_n);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
  end

  assign bus.dispatch_rdy = rdy;
  assign bus.alu_rs_we    = st_we[CLS_ALU];
  assign bus.mem_rs_we    = st_we[CLS_MEM];
  assign bus.br_rs_we     = st_we[CLS_BR];
  assign bus.alu_rs_insts = st_insts[CLS_ALU];
  assign bus.mem_rs_insts = st_insts[CLS_MEM];
  assign bus.br_rs_insts  = st_insts[CLS_BR];
endmodule

// File: tb/tb_dispatch.sv
// Directed testbench for dispatch (default build, no bypass): reset, routing, credits,
// backpressure, CDB snoop/forwarding and flush.
module tb_dispatch;
  import uarch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_if bus();
  dispatch #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  function automatic instruction_t mk(input opcode_t op, input logic [TAG_W-1:0] dst);
    instruction_t i;
    i          = '0;
    i.is_valid = 1'b1;
    i.opcode   = op;
    i.dst_tag  = dst;
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_credits(input logic [1:0] a, input logic [1:0] m, input logic [1:0] b);
    bus.alu_rs_credit = a;
    bus.mem_rs_credit = m;
    bus.br_rs_credit  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.cdb_ports = '0;
    set_credits(2, 2, 2);
    bus.renamed_insts = {mk(OPC_LOAD, 2), mk(OPC_ADD, 1)};
    tick();
    tick();
    #1;
    tests++; if (bus.dispatch_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b expected 0", bus.dispatch_rdy); end
    tests++; if ({bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we} !== '0) begin fails++; $display("FAIL reset_we: got %b expected 0", {bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we}); end
    tests++; if (bus.alu_rs_insts !== '0) begin fails++; $display("FAIL reset_insts: got %h expected 0", bus.alu_rs_insts); end
    rst = 1'b0;
    bus.renamed_insts = '0;
    #1;
    tests++; if (bus.dispatch_rdy !== 1'b1) begin fails++; $display("FAIL reset_release_rdy: got %b expected 1", bus.dispatch_rdy); end
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_mixed();
    set_credits(2, 2, 2);
    bus.renamed_insts = {mk(OPC_LOAD, 2), mk(OPC_ADD, 1)};
    #1;
    tests++; if (bus.alu_rs_we !== 2'b00) begin fails++; $display("FAIL mixed_latency: got %b expected 00", bus.alu_rs_we); end
    tick();
    bus.renamed_insts = '0;
    #1;
    tests++; if (dut.count_q !== 3'd2) begin fails++; $display("FAIL mixed_count: got %0d expected 2", dut.count_q); end
    tests++; if (bus.alu_rs_we !== 2'b01) begin fails++; $display("FAIL mixed_alu_we: got %b expected 01", bus.alu_rs_we); end
    tests++; if (bus.mem_rs_we !== 2'b01) begin fails++; $display("FAIL mixed_mem_we: got %b expected 01", bus.mem_rs_we); end
    tests++; if (bus.br_rs_we !== 2'b00) begin fails++; $display("FAIL mixed_br_we: got %b expected 00", bus.br_rs_we); end
    tests++; if (bus.alu_rs_insts[0].dst_tag !== 6'd1) begin fails++; $display("FAIL mixed_alu_tag: got %0d expected 1", bus.alu_rs_insts[0].dst_tag); end
    tests++; if (bus.mem_rs_insts[0].opcode !== OPC_LOAD) begin fails++; $display("FAIL mixed_mem_op: got %0d expected %0d", bus.mem_rs_insts[0].opcode, OPC_LOAD); end
    tests++; if (bus.alu_rs_insts[1] !== '0) begin fails++; $display("FAIL mixed_unused_lane: got %h expected 0", bus.alu_rs_insts[1]); end
    tick();
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL mixed_drain: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_classify();
    instruction_t [PIPE_WIDTH-1:0] grp [3];
    logic [5:0] exp_we [3];
    grp[0] = {mk(OPC_JAL, 6), mk(OPC_STORE, 5)};     exp_we[0] = 6'b00_01_01;
    grp[1] = {mk(OPC_JALR, 8), mk(OPC_BRANCH, 7)};   exp_we[1] = 6'b00_00_11;
    grp[2] = {mk(OPC_LOAD, 10), mk(OPC_OR, 9)};      exp_we[2] = 6'b01_01_00;
    set_credits(2, 2, 2);
    for (int g = 0; g < 3; g++) begin
      bus.renamed_insts = grp[g];
      tick();
      bus.renamed_insts = '0;
      #1;
      tests++;
      if ({bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we} !== exp_we[g]) begin
        fails++;
        $display("FAIL classify_%0d: got alu/mem/br %b expected %b", g, {bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we}, exp_we[g]);
      end
    end
    tick();
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL classify_drain: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_credit_stall();
    set_credits(1, 2, 2);
    bus.renamed_insts = {mk(OPC_ADD, 4), mk(OPC_ADD, 3)};
    tick();
    bus.renamed_insts = {mk(OPC_BRANCH, 5), instruction_t'('0)};
    #1;
    tests++; if (bus.alu_rs_we !== 2'b01 || bus.alu_rs_insts[0].dst_tag !== 6'd3) begin fails++; $display("FAIL stall_first: got we %b tag %0d expected 01 tag 3", bus.alu_rs_we, bus.alu_rs_insts[0].dst_tag); end
    tick();
    bus.renamed_insts = '0;
    set_credits(0, 2, 2);
    #1;
    tests++; if (dut.count_q !== 3'd2) begin fails++; $display("FAIL stall_one_entry: got %0d expected 2", dut.count_q); end
    tests++; if (bus.alu_rs_we !== 2'b00 || bus.br_rs_we !== 2'b00) begin fails++; $display("FAIL stall_no_pass: got alu %b br %b expected 00 00", bus.alu_rs_we, bus.br_rs_we); end
    tick();
    set_credits(1, 2, 2);
    #1;
    tests++; if (bus.alu_rs_we !== 2'b01 || bus.alu_rs_insts[0].dst_tag !== 6'd4) begin fails++; $display("FAIL stall_second: got we %b tag %0d expected 01 tag 4", bus.alu_rs_we, bus.alu_rs_insts[0].dst_tag); end
    tests++; if (bus.br_rs_we !== 2'b01 || bus.br_rs_insts[0].dst_tag !== 6'd5) begin fails++; $display("FAIL stall_branch: got we %b tag %0d expected 01 tag 5", bus.br_rs_we, bus.br_rs_insts[0].dst_tag); end
    tick();
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL stall_drain: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_backpressure();
    set_credits(0, 0, 0);
    bus.renamed_insts = {mk(OPC_ADD, 11), mk(OPC_ADD, 10)};
    tick();
    bus.renamed_insts = {mk(OPC_ADD, 13), mk(OPC_LOAD, 12)};
    #1;
    tests++; if (bus.dispatch_rdy !== 1'b1) begin fails++; $display("FAIL bp_rdy_g2: got %b expected 1", bus.dispatch_rdy); end
    tick();
    bus.renamed_insts = {mk(OPC_ADD, 15), mk(OPC_BRANCH, 14)};
    #1;
    tests++; if (bus.dispatch_rdy !== 1'b0 || dut.count_q !== 3'd4) begin fails++; $display("FAIL bp_full: got rdy %b count %0d expected 0 4", bus.dispatch_rdy, dut.count_q); end
    tests++; if ({bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we} !== '0) begin fails++; $display("FAIL bp_no_credit: got %b expected 0", {bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we}); end
    tick();
    tests++; if (dut.count_q !== 3'd4) begin fails++; $display("FAIL bp_held: got %0d expected 4", dut.count_q); end
    set_credits(2, 2, 2);
    #1;
    tests++; if (bus.alu_rs_we !== 2'b11 || bus.alu_rs_insts[0].dst_tag !== 6'd10 || bus.alu_rs_insts[1].dst_tag !== 6'd11) begin fails++; $display("FAIL bp_drain1: got we %b tags %0d %0d expected 11 10 11", bus.alu_rs_we, bus.alu_rs_insts[0].dst_tag, bus.alu_rs_insts[1].dst_tag); end
    tick();
    tests++; if (bus.dispatch_rdy !== 1'b1 || dut.count_q !== 3'd2) begin fails++; $display("FAIL bp_reopen: got rdy %b count %0d expected 1 2", bus.dispatch_rdy, dut.count_q); end
    tests++; if (bus.mem_rs_we !== 2'b01 || bus.mem_rs_insts[0].dst_tag !== 6'd12 || bus.alu_rs_insts[0].dst_tag !== 6'd13) begin fails++; $display("FAIL bp_drain2: got mem we %b tags %0d %0d expected 01 12 13", bus.mem_rs_we, bus.mem_rs_insts[0].dst_tag, bus.alu_rs_insts[0].dst_tag); end
    tick();
    bus.renamed_insts = '0;
    #1;
    tests++; if (bus.br_rs_we !== 2'b01 || bus.br_rs_insts[0].dst_tag !== 6'd14 || bus.alu_rs_insts[0].dst_tag !== 6'd15) begin fails++; $display("FAIL bp_drain3: got br we %b tags %0d %0d expected 01 14 15", bus.br_rs_we, bus.br_rs_insts[0].dst_tag, bus.alu_rs_insts[0].dst_tag); end
    tick();
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL bp_empty: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_cdb_snoop();
    instruction_t w;
    w = mk(OPC_ADD, 20);
    w.src_1_a = '{is_renamed: 1'b1, tag: 6'd5, data: 32'h0};
    w.src_0_b = '{is_renamed: 1'b0, tag: 6'd0, data: 32'h1234};
    // Broadcast while the entry sits in the buffer
    set_credits(0, 2, 2);
    bus.renamed_insts = {instruction_t'('0), w};
    tick();
    bus.renamed_insts = '0;
    bus.cdb_ports[0] = '{valid: 1'b1, tag: 6'd7, data: 32'h1111};
    bus.cdb_ports[1] = '{valid: 1'b1, tag: 6'd5, data: 32'hDEAD};
    tick();
    bus.cdb_ports = '0;
    set_credits(1, 2, 2);
    #1;
    tests++; if (bus.alu_rs_we !== 2'b01 || bus.alu_rs_insts[0].src_1_a.is_renamed !== 1'b0 || bus.alu_rs_insts[0].src_1_a.data !== 32'hDEAD) begin fails++; $display("FAIL snoop_buffered: got we %b ren %b data %h expected 01 0 dead", bus.alu_rs_we, bus.alu_rs_insts[0].src_1_a.is_renamed, bus.alu_rs_insts[0].src_1_a.data); end
    tests++; if (bus.alu_rs_insts[0].src_1_a.tag !== 6'd0 || bus.alu_rs_insts[0].src_0_b.data !== 32'h1234) begin fails++; $display("FAIL snoop_fields: got tag %0d src_0_b %h expected 0 1234", bus.alu_rs_insts[0].src_1_a.tag, bus.alu_rs_insts[0].src_0_b.data); end
    tick();
    // Broadcast in the dispatch cycle
    set_credits(0, 2, 2);
    bus.renamed_insts = {instruction_t'('0), w};
    tick();
    bus.renamed_insts = '0;
    set_credits(1, 2, 2);
    bus.cdb_ports[1] = '{valid: 1'b1, tag: 6'd5, data: 32'hDEAD};
    #1;
    tests++; if (bus.alu_rs_insts[0].src_1_a.is_renamed !== 1'b0 || bus.alu_rs_insts[0].src_1_a.data !== 32'hDEAD) begin fails++; $display("FAIL snoop_forward: got ren %b data %h expected 0 dead", bus.alu_rs_insts[0].src_1_a.is_renamed, bus.alu_rs_insts[0].src_1_a.data); end
    tick();
    bus.cdb_ports = '0;
    // Broadcast on the incoming lane; two matching ports, port 0 must win
    w = mk(OPC_ADD, 21);
    w.src_0_a = '{is_renamed: 1'b1, tag: 6'd9, data: 32'h0};
    set_credits(0, 2, 2);
    bus.renamed_insts = {instruction_t'('0), w};
    bus.cdb_ports[0] = '{valid: 1'b1, tag: 6'd9, data: 32'hAAAA};
    bus.cdb_ports[1] = '{valid: 1'b1, tag: 6'd9, data: 32'hBBBB};
    tick();
    bus.renamed_insts = '0;
    bus.cdb_ports = '0;
    set_credits(1, 2, 2);
    #1;
    tests++; if (bus.alu_rs_insts[0].src_0_a.is_renamed !== 1'b0 || bus.alu_rs_insts[0].src_0_a.data !== 32'hAAAA) begin fails++; $display("FAIL snoop_incoming_prio: got ren %b data %h expected 0 aaaa", bus.alu_rs_insts[0].src_0_a.is_renamed, bus.alu_rs_insts[0].src_0_a.data); end
    tick();
    tests++; if (dut.count_q !== 3'd0) begin fails++; $display("FAIL snoop_drain: got %0d expected 0", dut.count_q); end
  endtask

  task automatic test_flush();
    set_credits(0, 0, 0);
    bus.renamed_insts = {mk(OPC_ADD, 31), mk(OPC_ADD, 30)};
    tick();
    bus.renamed_insts = {instruction_t'('0), mk(OPC_ADD, 32)};
    tick();
    bus.renamed_insts = {mk(OPC_ADD, 34), mk(OPC_ADD, 33)};
    bus.flush = 1'b1;
    set_credits(2, 2, 2);
    #1;
    tests++; if (dut.count_q !== 3'd3) begin fails++; $display("FAIL flush_precount: got %0d expected 3", dut.count_q); end
    tests++; if ({bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we} !== '0) begin fails++; $display("FAIL flush_we: got %b expected 0", {bus.alu_rs_we, bus.mem_rs_we, bus.br_rs_we}); end
    tick();
    bus.flush = 1'b0;
    bus.renamed_insts = '0;
    #1;
    tests++; if (dut.count_q !== 3'd0 || bus.alu_rs_we !== 2'b00 || bus.dispatch_rdy !== 1'b1) begin fails++; $display("FAIL flush_after: got count %0d we %b rdy %b expected 0 00 1", dut.count_q, bus.alu_rs_we, bus.dispatch_rdy); end
    // Flush on an empty buffer with an accepted group: group must be dropped
    bus.renamed_insts = {mk(OPC_ADD, 36), mk(OPC_ADD, 35)};
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.renamed_insts = '0;
    #1;
    tests++; if (dut.count_q !== 3'd0 || bus.alu_rs_we !== 2'b00) begin fails++; $display("FAIL flush_discard: got count %0d we %b expected 0 00", dut.count_q, bus.alu_rs_we); end
    bus.renamed_insts = {instruction_t'('0), mk(OPC_SUB, 40)};
    tick();
    bus.renamed_insts = '0;
    #1;
    tests++; if (bus.alu_rs_we !== 2'b01 || bus.alu_rs_insts[0].dst_tag !== 6'd40) begin fails++; $display("FAIL flush_resume: got we %b tag %0d expected 01 40", bus.alu_rs_we, bus.alu_rs_insts[0].dst_tag); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_classify();
    test_credit_stall();
    test_backpressure();
    test_cdb_snoop();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
